// File: rtl/dm_pkg.sv
// Shared types for the data-memory responder: host FSM states, bus command
// decoding and the registered host response.
package dm_pkg;

    localparam int DM_WORD_W = 32;

    typedef enum logic [0:0] {
        H_IDLE = 1'b0,
        H_RESP = 1'b1
    } dm_host_state_t;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'd0,
        BUS_LOAD  = 2'd1,
        BUS_STORE = 2'd2
    } dm_bus_cmd_t;

    typedef struct packed {
        logic                 err;
        logic [DM_WORD_W-1:0] rdata;
    } dm_rsp_t;

    // The unused fourth encoding behaves as an idle bus cycle.
    function automatic dm_bus_cmd_t dm_cmd_decode(input logic [1:0] cmd);
        case (cmd)
            2'd1:    return BUS_LOAD;
            2'd2:    return BUS_STORE;
            default: return BUS_NONE;
        endcase
    endfunction

endpackage

// File: rtl/dm_addr_chk.sv
// Combinational address check: word alignment plus BASE_ADDR/DEPTH window,
// producing the array index of a byte address.
module dm_addr_chk #(
    parameter int          DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          IDX_W     = $clog2(DEPTH)
) (
    input  logic [31:0]      i_addr,
    output logic             o_good,
    output logic [IDX_W-1:0] o_index
);

    logic [31:0] w_off;

    // Offset wraps modulo 2^32, so addresses below BASE_ADDR land far out of range.
    assign w_off   = i_addr - BASE_ADDR;
    assign o_good  = (w_off[1:0] == 2'b00) && ((w_off[31:2] >> IDX_W) == 30'd0);
    assign o_index = w_off[IDX_W+1:2];

endmodule

// File: rtl/data_mem_responder.sv
// Zero-latency data memory for the MEM stage with a handshaked host port for
// preload/readback. Optional load/store statistics under DM_STATS_EN.
module data_mem_responder
    import dm_pkg::*;
#(
    parameter int          DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           MEM_mem_cmd,
    input  logic [31:0]          MEM_mem_addr,
    input  logic [31:0]          MEM_mem_din,
    output logic [DM_WORD_W-1:0] DM_mem_dout,
    input  logic                 host_req_vld,
    output logic                 host_req_rdy,
    input  logic                 host_req_we,
    input  logic [31:0]          host_req_addr,
    input  logic [31:0]          host_req_wdata,
    output logic                 host_rsp_vld,
    output logic [31:0]          host_rsp_rdata,
    output logic                 host_rsp_err,
    output logic                 dm_err,
    output logic [31:0]          dm_load_cnt,
    output logic [31:0]          dm_store_cnt
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [DM_WORD_W-1:0] r_mem [DEPTH];
    dm_host_state_t       r_state;
    dm_host_state_t       w_state_nxt;
    dm_rsp_t              r_rsp;
    logic                 r_dm_err;

    dm_bus_cmd_t          w_cmd;
    logic                 w_ld;
    logic                 w_st;
    logic                 w_mem_good;
    logic [IDX_W-1:0]     w_mem_idx;
    logic                 w_host_good;
    logic [IDX_W-1:0]     w_host_idx;
    logic                 w_hs;

    dm_addr_chk #(.DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR), .IDX_W(IDX_W)) u_mem_chk (
        .i_addr  (MEM_mem_addr),
        .o_good  (w_mem_good),
        .o_index (w_mem_idx)
    );

    dm_addr_chk #(.DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR), .IDX_W(IDX_W)) u_host_chk (
        .i_addr  (host_req_addr),
        .o_good  (w_host_good),
        .o_index (w_host_idx)
    );

    assign w_cmd = dm_cmd_decode(MEM_mem_cmd);
    assign w_ld  = (w_cmd == BUS_LOAD);
    assign w_st  = (w_cmd == BUS_STORE);
    assign w_hs  = host_req_vld && host_req_rdy;

    assign DM_mem_dout = (w_ld && w_mem_good) ? r_mem[w_mem_idx] : '0;

    // Host FSM: state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= H_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Host FSM: next state. The response cycle always lasts exactly one clock.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            H_IDLE:  if (w_hs) w_state_nxt = H_RESP;
            H_RESP:  w_state_nxt = H_IDLE;
            default: w_state_nxt = H_IDLE;
        endcase
    end

    // Host FSM: outputs. The processor owns the array whenever it issues a command.
    always_comb begin
        host_req_rdy = (r_state == H_IDLE) && (w_cmd == BUS_NONE);
        host_rsp_vld = (r_state == H_RESP);
    end

    assign host_rsp_rdata = r_rsp.rdata;
    assign host_rsp_err   = r_rsp.err;

    // Processor and host writes are mutually exclusive by the rdy rule.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_st && w_mem_good) begin
            r_mem[w_mem_idx] <= MEM_mem_din;
        end else if (w_hs && host_req_we && w_host_good) begin
            r_mem[w_host_idx] <= host_req_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp <= '0;
        end else if (w_hs) begin
            r_rsp.err   <= !w_host_good;
            r_rsp.rdata <= (!host_req_we && w_host_good) ? r_mem[w_host_idx] : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dm_err <= 1'b0;
        end else if ((w_ld || w_st) && !w_mem_good) begin
            r_dm_err <= 1'b1;
        end
    end

    assign dm_err = r_dm_err;

`ifdef DM_STATS_EN
    logic [31:0] r_load_cnt;
    logic [31:0] r_store_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_load_cnt  <= '0;
            r_store_cnt <= '0;
        end else begin
            if (w_ld && w_mem_good) r_load_cnt  <= r_load_cnt + 32'd1;
            if (w_st && w_mem_good) r_store_cnt <= r_store_cnt + 32'd1;
        end
    end

    assign dm_load_cnt  = r_load_cnt;
    assign dm_store_cnt = r_store_cnt;
`else
    assign dm_load_cnt  = 32'h0;
    assign dm_store_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: processor loads/stores, host port
// handshake, error flags, reset during a response and the optional counters.
module tb_data_mem_responder;
    import dm_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  MEM_mem_cmd;
    logic [31:0] MEM_mem_addr;
    logic [31:0] MEM_mem_din;
    logic [31:0] DM_mem_dout;
    logic        host_req_vld;
    logic        host_req_rdy;
    logic        host_req_we;
    logic [31:0] host_req_addr;
    logic [31:0] host_req_wdata;
    logic        host_rsp_vld;
    logic [31:0] host_rsp_rdata;
    logic        host_rsp_err;
    logic        dm_err;
    logic [31:0] dm_load_cnt;
    logic [31:0] dm_store_cnt;

    int checks = 0;
    int errors = 0;

    data_mem_responder dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .MEM_mem_cmd    (MEM_mem_cmd),
        .MEM_mem_addr   (MEM_mem_addr),
        .MEM_mem_din    (MEM_mem_din),
        .DM_mem_dout    (DM_mem_dout),
        .host_req_vld   (host_req_vld),
        .host_req_rdy   (host_req_rdy),
        .host_req_we    (host_req_we),
        .host_req_addr  (host_req_addr),
        .host_req_wdata (host_req_wdata),
        .host_rsp_vld   (host_rsp_vld),
        .host_rsp_rdata (host_rsp_rdata),
        .host_rsp_err   (host_rsp_err),
        .dm_err         (dm_err),
        .dm_load_cnt    (dm_load_cnt),
        .dm_store_cnt   (dm_store_cnt)
    );

    always #5 clk = ~clk;

    // Drives one processor command in the current cycle, samples the
    // combinational load data, and returns at the next falling edge.
    task automatic proc_cycle(input logic [1:0] cmd, input logic [31:0] addr,
                              input logic [31:0] din, output logic [31:0] dout);
        MEM_mem_cmd  = cmd;
        MEM_mem_addr = addr;
        MEM_mem_din  = din;
        #1;
        dout = DM_mem_dout;
        @(negedge clk);
        MEM_mem_cmd = BUS_NONE;
    endtask

    // One host request with the processor idle; reports the strobe in the
    // cycle after the handshake and whether it was still high a cycle later.
    task automatic host_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                               output logic seen, output logic [31:0] rdata,
                               output logic err, output logic extra);
        int waited;
        host_req_vld   = 1'b1;
        host_req_we    = we;
        host_req_addr  = addr;
        host_req_wdata = wdata;
        #1;
        waited = 0;
        while (!host_req_rdy && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!host_req_rdy) begin
            host_req_vld = 1'b0;
            seen  = 1'b0;
            rdata = 32'hx;
            err   = 1'bx;
            extra = 1'bx;
            @(negedge clk);
        end else begin
            @(posedge clk);
            @(negedge clk);
            host_req_vld = 1'b0;
            #1;
            seen  = host_rsp_vld;
            rdata = host_rsp_rdata;
            err   = host_rsp_err;
            @(negedge clk);
            #1;
            extra = host_rsp_vld;
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        checks++; if (host_rsp_vld !== 1'b0) begin errors++; $display("FAIL reset_rsp_vld got %0b want 0", host_rsp_vld); end
        checks++; if (host_rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata got %h want 0", host_rsp_rdata); end
        checks++; if (host_rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got %0b want 0", host_rsp_err); end
        checks++; if (dm_err !== 1'b0) begin errors++; $display("FAIL reset_dm_err got %0b want 0", dm_err); end
        checks++; if (dm_load_cnt !== 32'h0 || dm_store_cnt !== 32'h0) begin errors++; $display("FAIL reset_cnt got %h/%h want 0/0", dm_load_cnt, dm_store_cnt); end
        checks++; if (host_req_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy got %0b want 1", host_req_rdy); end
        @(negedge clk);
        rst_n = 1'b1;
        proc_cycle(BUS_LOAD, 32'h10, 32'h0, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_load got %h want 0", d); end
    endtask

    task automatic test_host_write_proc_load();
        logic seen, err, extra;
        logic [31:0] rd, d;
        host_access(1'b1, 32'h10, 32'hDEAD_BEEF, seen, rd, err, extra);
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL hw_rsp_vld got %0b want 1", seen); end
        checks++; if (extra !== 1'b0) begin errors++; $display("FAIL hw_rsp_pulse got %0b want 0", extra); end
        checks++; if (rd !== 32'h0 || err !== 1'b0) begin errors++; $display("FAIL hw_rsp_data got %h/%0b want 0/0", rd, err); end
        proc_cycle(BUS_LOAD, 32'h10, 32'h0, d);
        checks++; if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL hw_proc_load got %h want deadbeef", d); end
    endtask

    task automatic test_store_load();
        logic seen, err, extra;
        logic [31:0] rd, d;
        proc_cycle(BUS_STORE, 32'h20, 32'h1234_5678, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL st_dout_on_store got %h want 0", d); end
        proc_cycle(BUS_LOAD, 32'h20, 32'h0, d);
        checks++; if (d !== 32'h1234_5678) begin errors++; $display("FAIL st_next_load got %h want 12345678", d); end
        host_access(1'b0, 32'h20, 32'h0, seen, rd, err, extra);
        checks++; if (seen !== 1'b1 || rd !== 32'h1234_5678 || err !== 1'b0) begin errors++; $display("FAIL st_host_read got vld %0b data %h err %0b want 1 12345678 0", seen, rd, err); end
    endtask

    task automatic test_back_to_back();
        host_req_vld   = 1'b1;
        host_req_we    = 1'b0;
        host_req_addr  = 32'h10;
        host_req_wdata = 32'h0;
        MEM_mem_cmd    = BUS_LOAD;
        MEM_mem_addr   = 32'h10;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (host_req_rdy !== 1'b0) begin errors++; $display("FAIL b2b_rdy_busy%0d got %0b want 0", k, host_req_rdy); end
            checks++; if (DM_mem_dout !== 32'hDEAD_BEEF) begin errors++; $display("FAIL b2b_load%0d got %h want deadbeef", k, DM_mem_dout); end
            @(negedge clk);
        end
        MEM_mem_cmd = BUS_NONE;
        #1;
        checks++; if (host_req_rdy !== 1'b1) begin errors++; $display("FAIL b2b_rdy_free got %0b want 1", host_req_rdy); end
        checks++; if (host_rsp_vld !== 1'b0) begin errors++; $display("FAIL b2b_no_early_rsp got %0b want 0", host_rsp_vld); end
        @(posedge clk);
        @(negedge clk);
        host_req_vld = 1'b0;
        #1;
        checks++; if (host_rsp_vld !== 1'b1 || host_rsp_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL b2b_rsp got vld %0b data %h want 1 deadbeef", host_rsp_vld, host_rsp_rdata); end
        @(negedge clk);
        #1;
        checks++; if (host_rsp_vld !== 1'b0) begin errors++; $display("FAIL b2b_rsp_pulse got %0b want 0", host_rsp_vld); end
    endtask

    task automatic test_errors();
        logic seen, err, extra;
        logic [31:0] rd, d;
        proc_cycle(2'b11, 32'h10, 32'h0, d);
        checks++; if (d !== 32'h0 || host_req_rdy !== 1'b1) begin errors++; $display("FAIL cmd3_idle got dout %h rdy %0b want 0 1", d, host_req_rdy); end
        checks++; if (dm_err !== 1'b0) begin errors++; $display("FAIL dm_err_pre got %0b want 0", dm_err); end
        proc_cycle(BUS_LOAD, 32'h3, 32'h0, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL misalign_load got %h want 0", d); end
        #1;
        checks++; if (dm_err !== 1'b1) begin errors++; $display("FAIL dm_err_set got %0b want 1", dm_err); end
        proc_cycle(BUS_STORE, 32'h400, 32'hFFFF_FFFF, d);
        proc_cycle(BUS_LOAD, 32'h0, 32'h0, d);
        checks++; if (d !== 32'h0 || dm_err !== 1'b1) begin errors++; $display("FAIL bad_store_dropped got %h err %0b want 0 1", d, dm_err); end
        host_access(1'b0, 32'h400, 32'h0, seen, rd, err, extra);
        checks++; if (seen !== 1'b1 || err !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL host_oor_read got vld %0b err %0b data %h want 1 1 0", seen, err, rd); end
        host_access(1'b1, 32'h11, 32'h5555_5555, seen, rd, err, extra);
        checks++; if (err !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL host_misalign_wr got err %0b data %h want 1 0", err, rd); end
        host_access(1'b0, 32'h10, 32'h0, seen, rd, err, extra);
        checks++; if (rd !== 32'hDEAD_BEEF || err !== 1'b0) begin errors++; $display("FAIL host_bad_wr_dropped got %h err %0b want deadbeef 0", rd, err); end
        host_access(1'b1, 32'h3FC, 32'hCAFE_F00D, seen, rd, err, extra);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL host_last_word_err got %0b want 0", err); end
        proc_cycle(BUS_LOAD, 32'h3FC, 32'h0, d);
        checks++; if (d !== 32'hCAFE_F00D) begin errors++; $display("FAIL last_word_load got %h want cafef00d", d); end
        checks++; if (dm_err !== 1'b1) begin errors++; $display("FAIL dm_err_sticky got %0b want 1", dm_err); end
    endtask

    task automatic test_read_snapshot();
        logic [31:0] d;
        host_req_vld  = 1'b1;
        host_req_we   = 1'b0;
        host_req_addr = 32'h20;
        #1;
        checks++; if (host_req_rdy !== 1'b1) begin errors++; $display("FAIL snap_rdy got %0b want 1", host_req_rdy); end
        @(posedge clk);
        @(negedge clk);
        host_req_vld = 1'b0;
        proc_cycle(BUS_STORE, 32'h20, 32'hAAAA_5555, d);
        // proc_cycle sampled #1 into the response cycle; the response register is checked next.
        checks++; if (host_rsp_rdata !== 32'h1234_5678) begin errors++; $display("FAIL snap_rsp got %h want 12345678", host_rsp_rdata); end
        proc_cycle(BUS_LOAD, 32'h20, 32'h0, d);
        checks++; if (d !== 32'hAAAA_5555) begin errors++; $display("FAIL snap_store_landed got %h want aaaa5555", d); end
    endtask

    task automatic test_reset_in_resp();
        logic [31:0] d;
        host_req_vld   = 1'b1;
        host_req_we    = 1'b1;
        host_req_addr  = 32'h40;
        host_req_wdata = 32'h0000_0055;
        @(posedge clk);
        @(negedge clk);
        host_req_vld = 1'b0;
        #1;
        checks++; if (host_rsp_vld !== 1'b1) begin errors++; $display("FAIL rst_pre_vld got %0b want 1", host_rsp_vld); end
        rst_n = 1'b0;
        #1;
        checks++; if (host_rsp_vld !== 1'b0 || dm_err !== 1'b0) begin errors++; $display("FAIL rst_in_resp got vld %0b err %0b want 0 0", host_rsp_vld, dm_err); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++; if (host_rsp_vld !== 1'b0) begin errors++; $display("FAIL rst_no_strobe%0d got %0b want 0", k, host_rsp_vld); end
            @(negedge clk);
        end
        proc_cycle(BUS_LOAD, 32'h10, 32'h0, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_array_10 got %h want 0", d); end
        proc_cycle(BUS_LOAD, 32'h40, 32'h0, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_array_40 got %h want 0", d); end
    endtask

    task automatic test_stats();
        logic seen, err, extra;
        logic [31:0] rd, d;
        logic [31:0] exp_ld, exp_st;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        proc_cycle(BUS_LOAD, 32'h0, 32'h0, d);
        proc_cycle(BUS_LOAD, 32'h4, 32'h0, d);
        proc_cycle(BUS_STORE, 32'h8, 32'h1, d);
        proc_cycle(BUS_LOAD, 32'h10, 32'h0, d);
        proc_cycle(BUS_STORE, 32'h6, 32'h2, d);
        proc_cycle(BUS_LOAD, 32'h400, 32'h0, d);
        host_access(1'b1, 32'h30, 32'h3, seen, rd, err, extra);
        host_access(1'b0, 32'h30, 32'h0, seen, rd, err, extra);
        proc_cycle(BUS_STORE, 32'hC, 32'h4, d);
        proc_cycle(BUS_LOAD, 32'h3FC, 32'h0, d);
        proc_cycle(BUS_LOAD, 32'h20, 32'h0, d);
        #1;
`ifdef DM_STATS_EN
        exp_ld = 32'd5;
        exp_st = 32'd2;
`else
        exp_ld = 32'd0;
        exp_st = 32'd0;
`endif
        checks++; if (dm_load_cnt !== exp_ld) begin errors++; $display("FAIL stats_load got %0d want %0d", dm_load_cnt, exp_ld); end
        checks++; if (dm_store_cnt !== exp_st) begin errors++; $display("FAIL stats_store got %0d want %0d", dm_store_cnt, exp_st); end
        checks++; if (dm_err !== 1'b1) begin errors++; $display("FAIL stats_dm_err got %0b want 1", dm_err); end
    endtask

    initial begin
        rst_n          = 1'b0;
        MEM_mem_cmd    = BUS_NONE;
        MEM_mem_addr   = 32'h0;
        MEM_mem_din    = 32'h0;
        host_req_vld   = 1'b0;
        host_req_we    = 1'b0;
        host_req_addr  = 32'h0;
        host_req_wdata = 32'h0;
        #1;
        test_reset();
        test_host_write_proc_load();
        test_store_load();
        test_back_to_back();
        test_errors();
        test_read_snapshot();
        test_reset_in_resp();
        test_stats();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
